// File: rtl/recursive_moving_average_filter_param_pkg.sv
// Shared types and helpers for the recursive moving-average filter.
//   rmaf_state_t : fill/run state of the window
//   acc_w        : accumulator width that cannot overflow for a full window
//   clamp_win    : limits a requested window exponent to the supported maximum
package rmaf_pkg;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } rmaf_state_t;

  // A sum of 2**log2_n_max samples needs log2_n_max extra bits of headroom.
  function automatic int acc_w(input int data_w, input int log2_n_max);
    return data_w + log2_n_max;
  endfunction

  function automatic int clamp_win(input int win, input int win_max);
    if (win > win_max) begin
      return win_max;
    end else begin
      return win;
    end
  endfunction

endpackage

// File: rtl/recursive_moving_average_filter_param_if.sv
// Streaming bus of the moving-average filter.
//   clear, win_log2, in_valid, d : driven by the source (master)
//   out_valid, q, primed         : driven by the filter (slave)
interface recursive_moving_average_filter_param_if #(
  parameter int DATA_W     = 16,
  parameter int LOG2_N_MAX = 5
);

  logic                                clear;
  logic [$clog2(LOG2_N_MAX+1)-1:0]     win_log2;
  logic                                in_valid;
  logic signed [DATA_W-1:0]            d;
  logic                                out_valid;
  logic signed [DATA_W-1:0]            q;
  logic                                primed;

  modport master (
    output clear, win_log2, in_valid, d,
    input  out_valid, q, primed
  );

  modport slave (
    input  clear, win_log2, in_valid, d,
    output out_valid, q, primed
  );

endinterface

// File: rtl/recursive_moving_average_filter_param_delay_line.sv
// Circular sample buffer for the moving-average filter.
//   clk, reset_n : clock and async active-low reset (pointer only)
//   ptr_clr      : synchronous return of the write pointer to slot 0
//   wr_en/wr_data: store one sample and advance the pointer
//   rd_win       : window exponent; rd_data is the sample written 2**rd_win
//                  writes ago (combinational read, so it is valid in the
//                  same cycle as the write that replaces it)
// The storage itself is never reset; the filter ignores it until the window
// has been filled once.
module rmaf_delay_line #(
  parameter int DATA_W     = 16,
  parameter int LOG2_N_MAX = 5
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              ptr_clr,
  input  logic                              wr_en,
  input  logic signed [DATA_W-1:0]          wr_data,
  input  logic [$clog2(LOG2_N_MAX+1)-1:0]   rd_win,
  output logic signed [DATA_W-1:0]          rd_data
);

  localparam int DEPTH = 2**LOG2_N_MAX;

  logic [LOG2_N_MAX-1:0]    wr_ptr_r;
  logic [LOG2_N_MAX-1:0]    rd_addr_s;
  logic signed [DATA_W-1:0] mem_r [DEPTH];

  // For the largest window the shifted offset wraps to 0, i.e. the slot about
  // to be overwritten, which is exactly the oldest sample.
  assign rd_addr_s = wr_ptr_r - (LOG2_N_MAX'(1) << rd_win);
  assign rd_data   = mem_r[rd_addr_s];

  // Write pointer: cleared on flush, advances on every stored sample.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= {LOG2_N_MAX{1'b0}};
    end else if (ptr_clr) begin
      wr_ptr_r <= {LOG2_N_MAX{1'b0}};
    end else if (wr_en) begin
      wr_ptr_r <= wr_ptr_r + LOG2_N_MAX'(1);
    end else begin
      wr_ptr_r <= wr_ptr_r;
    end
  end

  // Sample storage, deliberately without reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

endmodule

// File: rtl/recursive_moving_average_filter_param.sv
// Recursive moving-average filter with run-time power-of-two window.
//   clk, reset_n : clock and async active-low reset
//   bus (slave)  : clear, win_log2, in_valid, d in; out_valid, q, primed out
// Each accepted sample updates acc by +d - d_old and q = acc >>> win with one
// cycle of latency. primed is high once the window holds N real samples.
module recursive_moving_average_filter_param
  import rmaf_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int LOG2_N_MAX = 5
) (
  input  logic clk,
  input  logic reset_n,
  recursive_moving_average_filter_param_if.slave bus
);

  localparam int WIN_W = $clog2(LOG2_N_MAX+1);
  localparam int CNT_W = LOG2_N_MAX + 1;
  localparam int ACC_W = acc_w(DATA_W, LOG2_N_MAX);

  rmaf_state_t              state_r;
  rmaf_state_t              state_nxt_s;
  logic                     first_r;
  logic [WIN_W-1:0]         win_lat_r;
  logic [WIN_W-1:0]         win_eff_s;
  logic [WIN_W-1:0]         win_use_s;
  logic                     flush_s;
  logic                     accept_s;
  logic [CNT_W-1:0]         fill_cnt_r;
  logic [CNT_W-1:0]         n_s;
  logic signed [ACC_W-1:0]  acc_r;
  logic signed [ACC_W-1:0]  acc_nxt_s;
  logic signed [ACC_W-1:0]  d_ext_s;
  logic signed [ACC_W-1:0]  d_old_ext_s;
  logic signed [DATA_W-1:0] rd_data_s;
  logic signed [DATA_W-1:0] d_old_s;
  logic signed [DATA_W-1:0] q_nxt_s;
  logic signed [DATA_W-1:0] q_r;
  logic                     out_valid_r;

  assign win_eff_s = WIN_W'(clamp_win(int'(bus.win_log2), LOG2_N_MAX));

  rmaf_delay_line #(
    .DATA_W     (DATA_W),
    .LOG2_N_MAX (LOG2_N_MAX)
  ) u_delay_line (
    .clk     (clk),
    .reset_n (reset_n),
    .ptr_clr (flush_s),
    .wr_en   (accept_s),
    .wr_data (bus.d),
    .rd_win  (win_use_s),
    .rd_data (rd_data_s)
  );

  // Window decode, flush/accept decision and accumulator arithmetic.
  always_comb begin
    win_use_s   = win_lat_r;
    flush_s     = 1'b0;
    d_old_s     = {DATA_W{1'b0}};
    // Right after reset the requested window is adopted without a flush.
    if (first_r) begin
      win_use_s = win_eff_s;
      flush_s   = bus.clear;
    end else begin
      win_use_s = win_lat_r;
      flush_s   = bus.clear | (win_eff_s != win_lat_r);
    end
    accept_s = bus.in_valid & ~flush_s;
    n_s      = CNT_W'(1) << win_use_s;
    // While filling, the delay line still holds stale data: subtract nothing.
    if (state_r == RUN) begin
      d_old_s = rd_data_s;
    end else begin
      d_old_s = {DATA_W{1'b0}};
    end
    d_ext_s     = {{LOG2_N_MAX{bus.d[DATA_W-1]}}, bus.d};
    d_old_ext_s = {{LOG2_N_MAX{d_old_s[DATA_W-1]}}, d_old_s};
    acc_nxt_s   = acc_r + d_ext_s - d_old_ext_s;
    q_nxt_s     = DATA_W'(acc_nxt_s >>> win_use_s);
  end

  // Next-state logic of the fill/run state machine.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      FILL: begin
        if (flush_s) begin
          state_nxt_s = FILL;
        end else if (accept_s && ((fill_cnt_r + CNT_W'(1)) == n_s)) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = FILL;
        end
      end
      RUN: begin
        if (flush_s) begin
          state_nxt_s = FILL;
        end else begin
          state_nxt_s = RUN;
        end
      end
      default: state_nxt_s = FILL;
    endcase
  end

  // State register, window latch and first-cycle marker.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= FILL;
      first_r   <= 1'b1;
      win_lat_r <= WIN_W'(LOG2_N_MAX);
    end else begin
      state_r   <= state_nxt_s;
      first_r   <= 1'b0;
      // Outside a flush the clamped request equals the latch, so always load.
      win_lat_r <= win_eff_s;
    end
  end

  // Accumulator and saturating fill counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_r      <= {ACC_W{1'b0}};
      fill_cnt_r <= {CNT_W{1'b0}};
    end else if (flush_s) begin
      acc_r      <= {ACC_W{1'b0}};
      fill_cnt_r <= {CNT_W{1'b0}};
    end else if (accept_s) begin
      acc_r <= acc_nxt_s;
      if (state_r == FILL) begin
        fill_cnt_r <= fill_cnt_r + CNT_W'(1);
      end else begin
        fill_cnt_r <= fill_cnt_r;
      end
    end else begin
      acc_r      <= acc_r;
      fill_cnt_r <= fill_cnt_r;
    end
  end

  // Output register: q holds between accepted samples.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_r         <= {DATA_W{1'b0}};
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= accept_s;
      if (accept_s) begin
        q_r <= q_nxt_s;
      end else begin
        q_r <= q_r;
      end
    end
  end

  assign bus.q         = q_r;
  assign bus.out_valid = out_valid_r;
  assign bus.primed    = (state_r == RUN);

endmodule

// File: doc/recursive_moving_average_filter_param.md
# recursive_moving_average_filter_param

Parametrised, streaming recursive moving-average filter: the generalised successor of the fixed 8-tap filter. Width and maximum window depth are parameters. The window length (a power of two) is selectable at run time. Input and output carry valid strobes, and a `primed` flag indicates that the window is full. It sits in the sample-rate datapath between a signal source (ROM, ADC front end) and downstream DSP.

## Interface
- `DATA_W`, 16: sample width, signed two's complement.
- `LOG2_N_MAX`, 5: log2 of the maximum window (32 taps); delay-line depth is 2**LOG2_N_MAX.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `clear` in 1: synchronous flush of the filter state; the window setting is kept.
- `win_log2` in $clog2(LOG2_N_MAX+1): window N = 2**win_log2; values above LOG2_N_MAX clamp to LOG2_N_MAX.
- `in_valid` in 1: `d` is a sample this cycle.
- `d` in DATA_W: signed input sample.
- `out_valid` out 1: `q` updated this cycle.
- `q` out DATA_W: signed average.
- `primed` out 1: at least N samples accepted since the last flush.

## Operation
- Accumulator `acc`:
  - Signed, width DATA_W+LOG2_N_MAX; it cannot overflow.
- On an accepted sample:
  - acc_next = acc + d − d_old, where d_old is the sample written N accepts earlier.
  - d is written to the circular delay line at `wr_ptr`; `wr_ptr` increments, wrapping modulo 2**LOG2_N_MAX.
  - d_old is read at (wr_ptr − N) mod 2**LOG2_N_MAX.
- Output computation:
  - q = acc_next >>> win_log2_eff: arithmetic shift, floor rounding, low DATA_W bits.
  - The result always fits in DATA_W.
- State machine, two states:
  - FILL: fill_cnt < N. d_old is forced to 0, so stale RAM contents are never subtracted and the delay line needs no reset.
  - FILL→RUN: on the accept that makes fill_cnt == N; `primed` is asserted in that cycle's registered output.
  - RUN: d_old is taken from the delay line; fill_cnt saturates.
- Flush:
  - Triggered by `clear`, or by `win_log2_eff` differing from the latched window.
  - Effect: acc←0, fill_cnt←0, wr_ptr←0, state←FILL, primed←0, and the new window is latched.
  - q holds its last value; out_valid←0.
- `clear` together with `in_valid`: clear wins and the sample is discarded.
- Window change together with `in_valid`: the flush applies and the sample is discarded.
- No `in_valid`: all state holds, out_valid←0, q holds.
- Reset values: q=0, out_valid=0, primed=0, acc=0, fill_cnt=0, wr_ptr=0, state=FILL, latched window = LOG2_N_MAX.
  - The window is latched from `win_log2` on the first cycle after reset deassertion, with no flush.

## Timing
- Latency: 1 clock. A sample accepted at edge k produces q/out_valid registered at edge k; visible in cycle k+1.
- Throughput: one sample per clock; in_valid may be held high continuously.
- The delay-line read is combinational from `wr_ptr`, or a registered read with the next-address prefetch. Either is acceptable, provided 1-cycle latency and back-to-back operation hold.
- `reset_n` assertion mid-stream: all outputs reach their reset values immediately (asynchronous); the first sample after release starts in FILL.
- `win_log2` is sampled every cycle; only changes of the clamped value cause a flush.

## Structure
- Package `rmaf_pkg` contains:
  - State enum `rmaf_state_t` {FILL, RUN}.
  - Function `acc_w(DATA_W, LOG2_N_MAX)`.
  - Clamp function for `win_log2`.
- Sub-module `rmaf_delay_line`:
  - Parametrised circular buffer (DATA_W × 2**LOG2_N_MAX).
  - One write port, one read port, internal `wr_ptr`, pointer reset.
  - Contents are not reset.
- The top level holds the accumulator, fill counter, FSM and output register.

## Test plan
- Step: N=8, d=32767 held valid.
  - q sequence 4095, 8191, 12287, 16383, 20479, 24575, 28671, 32767, then constant.
  - primed rises with the 8th output.
- Impulse: N=8, one sample 32767, then zeros.
  - q=4095 for 8 outputs, then 0 forever.
  - Again with reset between runs: identical result, proving d_old is zeroed in FILL.
- Rounding/sign: N=8, single d=−1, then zeros.
  - q=−1 for 8 outputs (floor), then 0.
  - d=−32768 held: q converges to −32768 with no wrap.
- Window switch and clamp:
  - Run N=8, then set win_log2=2 mid-stream with in_valid high: that sample is dropped, primed falls, and a refill of 4 samples follows.
  - win_log2=7 behaves exactly as 5.
  - N=1 gives q=d with 1-cycle latency.
- Gaps and clear:
  - Random in_valid gaps over low-frequency, high-frequency and noisy 1024-sample sine ROMs: results are bit-exact against a reference model.
  - clear+in_valid together discards the sample.
  - reset_n pulsed mid-stream zeroes all outputs asynchronously.
